// File: rtl/nn_sram_burst_read_slave_if.sv
// Avalon-MM read-only burst bus between the host and the SRAM read-back responder.
interface nn_sram_burst_read_slave_if;
  logic        read;
  logic [9:0]  burstcount;
  logic [12:0] address;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [1:0]  response;

  modport master (
    output read, burstcount, address,
    input  waitrequest, readdata, readdatavalid, response
  );

  modport slave (
    input  read, burstcount, address,
    output waitrequest, readdata, readdatavalid, response
  );
endinterface

// File: rtl/nn_sram_burst_read_slave.sv
// Burst read-back of the pixel and weight SRAMs: one SRAM read per cycle,
// beats returned two cycles after issue with readdatavalid and a per-beat response.
//
// state | meaning
// IDLE  | waiting for a command; waitrequest low unless compute_active
// ISSUE | one beat issued per cycle from cur_addr
// DRAIN | last beat in flight; leave once its readdatavalid is driven
module nn_sram_burst_read_slave #(
  parameter int PIXEL_BASE   = 0,
  parameter int PIXEL_WORDS  = 196,
  parameter int WEIGHT_BASE  = 196,
  parameter int WEIGHT_WORDS = 3920,
  parameter int MAX_BURST    = 512
) (
  input  logic                             clk,
  input  logic                             reset,
  nn_sram_burst_read_slave_if.slave        bus,
  input  logic                             compute_active,
  output logic                             sram_r_enable,
  output logic [11:0]                      weight_address,
  output logic [9:0]                       pixel_address1,
  output logic [9:0]                       pixel_address2,
  input  logic [31:0]                      weight_value,
  input  logic [15:0]                      pixel_value1,
  input  logic [15:0]                      pixel_value2
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef enum logic [1:0] {K_PIX, K_WGT, K_ERR} kind_t;

  localparam logic [12:0] PB = 13'(PIXEL_BASE);
  localparam logic [12:0] PW = 13'(PIXEL_WORDS);
  localparam logic [12:0] WB = 13'(WEIGHT_BASE);
  localparam logic [12:0] WW = 13'(WEIGHT_WORDS);
  localparam logic [9:0]  MB = 10'(MAX_BURST);

  state_t      state, state_nxt;
  logic [12:0] cur_addr;
  logic [9:0]  remaining;
  logic        bad_cmd;
  logic        s1_valid;
  kind_t       s1_kind;
  kind_t       beat_kind;
  logic        accept, legal;
  logic [12:0] pix_off, wgt_off;
  logic        in_pix, in_wgt;
  logic [31:0] data_q;
  logic        rdv_q;
  logic [1:0]  resp_q;

  assign bus.waitrequest   = (state != IDLE) | compute_active;
  assign bus.readdata      = data_q;
  assign bus.readdatavalid = rdv_q;
  assign bus.response      = resp_q;

  assign accept = bus.read & ~bus.waitrequest;
  assign legal  = (bus.burstcount != 10'd0) && (bus.burstcount <= MB);

  // Offsets wrap below the base, so a single unsigned compare covers both bounds.
  assign pix_off = cur_addr - PB;
  assign wgt_off = cur_addr - WB;
  assign in_pix  = pix_off < PW;
  assign in_wgt  = wgt_off < WW;

  always_comb begin
    state_nxt      = state;
    beat_kind      = K_ERR;
    sram_r_enable  = 1'b0;
    pixel_address1 = '0;
    pixel_address2 = '0;
    weight_address = '0;
    if (!bad_cmd && in_pix)      beat_kind = K_PIX;
    else if (!bad_cmd && in_wgt) beat_kind = K_WGT;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        sram_r_enable = (beat_kind != K_ERR);
        if (beat_kind == K_PIX) begin
          pixel_address1 = pix_off[9:0];
          pixel_address2 = pix_off[9:0];
        end
        if (beat_kind == K_WGT) weight_address = wgt_off[11:0];
        if (remaining == 10'd0) state_nxt = DRAIN;
      end
      DRAIN: if (!s1_valid && rdv_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      bad_cmd   <= 1'b0;
      s1_valid  <= 1'b0;
      s1_kind   <= K_ERR;
      data_q    <= '0;
      rdv_q     <= 1'b0;
      resp_q    <= 2'b00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cur_addr  <= bus.address;
        remaining <= legal ? bus.burstcount - 10'd1 : 10'd0;
        bad_cmd   <= ~legal;
      end else if (state == ISSUE) begin
        cur_addr <= cur_addr + 13'd1;
        if (remaining != 10'd0) remaining <= remaining - 10'd1;
      end
      // Stage 1 tracks the beat whose SRAM data arrives in the following cycle.
      s1_valid <= (state == ISSUE);
      s1_kind  <= beat_kind;
      rdv_q    <= s1_valid;
      resp_q   <= (s1_valid && s1_kind == K_ERR) ? 2'b10 : 2'b00;
      if (s1_valid && s1_kind == K_PIX)      data_q <= {pixel_value2, pixel_value1};
      else if (s1_valid && s1_kind == K_WGT) data_q <= weight_value;
      else                                   data_q <= '0;
    end
  end

endmodule
